rf_wport_arb: RTL and testbench

RF_WPORT_ARB -- requirements
Module: rf_wport_arb

---
 rtl/rf_wport_arb_pkg.sv | 29 ++
 rtl/rf_wport_arb_if.sv | 12 +
 rtl/wb_pend_fifo.sv | 81 ++++++++
 rtl/rf_wport_arb.sv | 107 ++++++++++
 tb/tb_rf_wport_arb.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wport_arb_pkg.sv
// Shared CPU write-back definitions: WB bus layout and the LU write bundle layout.
package rf_wport_arb_pkg;

  localparam int unsigned RF_ADDR_WD = 5;
  localparam int unsigned RF_DATA_WD = 32;

  // WB-stage write bus: {we, waddr, wdata}
  localparam int unsigned WS_TO_RF_BUS_WD = 38;
  localparam int unsigned WS_WE_BIT       = 37;
  localparam int unsigned WS_WADDR_LSB    = 32;
  localparam int unsigned WS_WDATA_LSB    = 0;

  // Long-latency unit write bundle: {waddr, wdata}
  localparam int unsigned LU_BUNDLE_WD = 37;
  localparam int unsigned LU_WADDR_LSB = 32;
  localparam int unsigned LU_WDATA_LSB = 0;

  typedef logic [LU_BUNDLE_WD-1:0] lu_wr_t;

  function automatic lu_wr_t pack_lu_wr(input logic [RF_ADDR_WD-1:0] waddr,
                                        input logic [RF_DATA_WD-1:0] wdata);
    lu_wr_t b;
    b = '0;
    b[LU_WADDR_LSB +: RF_ADDR_WD] = waddr;
    b[LU_WDATA_LSB +: RF_DATA_WD] = wdata;
    return b;
  endfunction

endpackage

// File: rtl/rf_wport_arb_if.sv
// Long-latency unit result handshake into the write-port arbiter.
interface rf_wport_arb_if;
  logic        lu_wb_valid;
  logic        lu_wb_ready;
  logic [4:0]  lu_wb_waddr;
  logic [31:0] lu_wb_wdata;

  modport master (output lu_wb_valid, output lu_wb_waddr, output lu_wb_wdata,
                  input lu_wb_ready);
  modport slave  (input lu_wb_valid, input lu_wb_waddr, input lu_wb_wdata,
                  output lu_wb_ready);
endinterface

// File: rtl/wb_pend_fifo.sv
// Pending LU write buffer: storage, per-entry valid (WAW squash), pointers, count
// and hazard-lookup compare.
module wb_pend_fifo
  import rf_wport_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  lu_wr_t                push_ent,
  input  logic                  pop,
  input  logic                  squash,
  input  logic [RF_ADDR_WD-1:0] squash_addr,
  input  logic [RF_ADDR_WD-1:0] rd_addr1,
  input  logic [RF_ADDR_WD-1:0] rd_addr2,
  output logic [$clog2(DEPTH):0] count,
  output logic                  head_valid,
  output logic [RF_ADDR_WD-1:0] head_waddr,
  output logic [RF_DATA_WD-1:0] head_wdata,
  output logic                  hit1,
  output logic                  hit2
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  lu_wr_t            mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;

  // Next valid bits: squash first, then pop, then push so a same-cycle push survives
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (squash && (mem_q[i][LU_WADDR_LSB +: RF_ADDR_WD] == squash_addr)) valid_d[i] = 1'b0;
      if (pop && (head_q == PtrW'(i)))  valid_d[i] = 1'b0;
      if (push && (tail_q == PtrW'(i))) valid_d[i] = 1'b1;
    end
  end

  // Control state: pointers, count, valid bits
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (pop)  head_q <= head_q + PtrW'(1);
      if (push) tail_q <= tail_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Entry payload; no reset needed since valid bits gate every use
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_ent;
  end

  // Head view and hazard lookup against currently buffered valid entries
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i][LU_WADDR_LSB +: RF_ADDR_WD] == rd_addr1)) hit1 = 1'b1;
      if (valid_q[i] && (mem_q[i][LU_WADDR_LSB +: RF_ADDR_WD] == rd_addr2)) hit2 = 1'b1;
    end
    if (rd_addr1 == '0) hit1 = 1'b0;
    if (rd_addr2 == '0) hit2 = 1'b0;
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0) && valid_q[head_q];
  assign head_waddr = mem_q[head_q][LU_WADDR_LSB +: RF_ADDR_WD];
  assign head_wdata = mem_q[head_q][LU_WDATA_LSB +: RF_DATA_WD];

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: WB writes pass through at zero latency, LU
// results are buffered and drained in WB-idle cycles, with starvation hold request.
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  rf_wport_arb_if.slave              lu,
  output logic                       rf_we,
  output logic [RF_ADDR_WD-1:0]      rf_waddr,
  output logic [RF_DATA_WD-1:0]      rf_wdata,
  input  logic [RF_ADDR_WD-1:0]      rd_addr1,
  input  logic [RF_ADDR_WD-1:0]      rd_addr2,
  output logic                       pend_hit1,
  output logic                       pend_hit2,
  output logic                       ws_hold
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  logic                  wb_we, wb_wr;
  logic [RF_ADDR_WD-1:0] wb_waddr;
  logic [RF_DATA_WD-1:0] wb_wdata;
  logic [CntW-1:0]       count;
  logic                  head_present, head_valid, drain, lu_push;
  logic [RF_ADDR_WD-1:0] head_waddr;
  logic [RF_DATA_WD-1:0] head_wdata;
  logic [StW-1:0]        starve_q, starve_d;
  logic                  ws_hold_q;

  assign wb_we    = ws_to_rf_bus[WS_WE_BIT];
  assign wb_waddr = ws_to_rf_bus[WS_WADDR_LSB +: RF_ADDR_WD];
  assign wb_wdata = ws_to_rf_bus[WS_WDATA_LSB +: RF_DATA_WD];
  assign wb_wr    = wb_we && (wb_waddr != '0);

  assign head_present   = (count != '0);
  // Reset gates draining so buffered writes are discarded, never emitted
  assign drain          = resetn && head_present && !wb_wr;
  // No bypass-through-full: a full buffer refuses even when draining this cycle
  assign lu.lu_wb_ready = resetn && (count < CntW'(DEPTH));
  assign lu_push        = lu.lu_wb_valid && lu.lu_wb_ready && (lu.lu_wb_waddr != '0);

  wb_pend_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push        (lu_push),
    .push_ent    (pack_lu_wr(lu.lu_wb_waddr, lu.lu_wb_wdata)),
    .pop         (drain),
    .squash      (wb_wr),
    .squash_addr (wb_waddr),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .count       (count),
    .head_valid  (head_valid),
    .head_waddr  (head_waddr),
    .head_wdata  (head_wdata),
    .hit1        (pend_hit1),
    .hit2        (pend_hit2)
  );

  // RF port mux: WB always wins; a squashed head drains silently
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (wb_wr) begin
      rf_we    = 1'b1;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (drain && head_valid) begin
      rf_we    = 1'b1;
      rf_waddr = head_waddr;
      rf_wdata = head_wdata;
    end
  end

  // Starvation counter: counts blocked cycles, saturates, clears on pop or empty
  always_comb begin
    starve_d = starve_q;
    if (drain || !head_present) begin
      starve_d = '0;
    end else if (wb_wr && (starve_q < StW'(STARVE_LIMIT))) begin
      starve_d = starve_q + StW'(1);
    end
  end

  // Registered hold request tracks the counter reaching the limit
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_q  <= '0;
      ws_hold_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      ws_hold_q <= (starve_d >= StW'(STARVE_LIMIT));
    end
  end

  assign ws_hold = ws_hold_q;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Randomized + directed bench for rf_wport_arb against a queue-based reference model.
module tb_rf_wport_arb;

  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [37:0] ws_to_rf_bus;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        pend_hit1, pend_hit2, ws_hold;

  rf_wport_arb_if lu_if ();

  rf_wport_arb #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ws_to_rf_bus (ws_to_rf_bus),
    .lu           (lu_if),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .pend_hit1    (pend_hit1),
    .pend_hit2    (pend_hit2),
    .ws_hold      (ws_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ment_t;

  ment_t       mq[$];
  int unsigned m_starve;
  bit          m_hold;
  logic [31:0] mdl_rf [32];
  bit          mdl_wr [32];
  int unsigned mdl_wr_cnt;

  // Register file as seen from the DUT write port
  logic [31:0] dut_rf [32];
  int unsigned dut_wr_cnt = 0;
  always @(posedge clk) begin
    if (rf_we) begin
      dut_rf[rf_waddr] <= rf_wdata;
      dut_wr_cnt <= dut_wr_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare against model, advance model across the edge
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic [4:0] r1, input logic [4:0] r2, input logic rn);
    bit          wbw, e_we, e_rdy, e_h1, e_h2, pop, push;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    @(posedge clk);
    #1;
    ws_to_rf_bus      = {we, wa, wd};
    lu_if.lu_wb_valid = lv;
    lu_if.lu_wb_waddr = la;
    lu_if.lu_wb_wdata = ld;
    rd_addr1          = r1;
    rd_addr2          = r2;
    resetn            = rn;
    #1;
    wbw   = we && (wa != 0);
    e_rdy = rn && (mq.size() < DEPTH);
    e_we  = 1'b0;
    e_a   = '0;
    e_d   = '0;
    if (wbw) begin
      e_we = 1'b1; e_a = wa; e_d = wd;
    end else if (rn && mq.size() > 0 && mq[0].v) begin
      e_we = 1'b1; e_a = mq[0].a; e_d = mq[0].d;
    end
    e_h1 = 1'b0;
    e_h2 = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].v && r1 != 0 && mq[i].a == r1) e_h1 = 1'b1;
      if (mq[i].v && r2 != 0 && mq[i].a == r2) e_h2 = 1'b1;
    end
    check_eq("rf_we", 64'(rf_we), 64'(e_we));
    check_eq("rf_waddr", 64'(rf_waddr), 64'(e_a));
    check_eq("rf_wdata", 64'(rf_wdata), 64'(e_d));
    check_eq("lu_wb_ready", 64'(lu_if.lu_wb_ready), 64'(e_rdy));
    check_eq("pend_hit1", 64'(pend_hit1), 64'(e_h1));
    check_eq("pend_hit2", 64'(pend_hit2), 64'(e_h2));
    check_eq("ws_hold", 64'(ws_hold), 64'(m_hold));

    if (e_we) begin
      mdl_rf[e_a] = e_d;
      mdl_wr[e_a] = 1'b1;
      mdl_wr_cnt++;
    end
    if (!rn) begin
      mq.delete();
      m_starve = 0;
      m_hold   = 1'b0;
    end else begin
      pop  = (mq.size() > 0) && !wbw;
      push = e_rdy && lv && (la != 0);
      if (pop || mq.size() == 0) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      m_hold = (m_starve >= STARVE_LIMIT);
      if (wbw) foreach (mq[i]) if (mq[i].a == wa) mq[i].v = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{a: la, d: ld, v: 1'b1});
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
  endtask

  task automatic wb_only(input logic [4:0] wa, input logic [31:0] wd);
    step(1'b1, wa, wd, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
  endtask

  task automatic wb_and_lu(input logic [4:0] wa, input logic [4:0] la, input logic [31:0] ld);
    step(1'b1, wa, 32'h1000 + 32'(wa), 1'b1, la, ld, 5'd0, 5'd0, 1'b1);
  endtask

  initial begin
    resetn            = 1'b0;
    ws_to_rf_bus      = '0;
    lu_if.lu_wb_valid = 1'b0;
    lu_if.lu_wb_waddr = '0;
    lu_if.lu_wb_wdata = '0;
    rd_addr1          = '0;
    rd_addr2          = '0;
    m_starve          = 0;
    m_hold            = 1'b0;
    mdl_wr_cnt        = 0;
    for (int r = 0; r < 32; r++) begin
      mdl_rf[r] = '0;
      mdl_wr[r] = 1'b0;
    end
    repeat (2) @(posedge clk);

    // Reset state, with WB passing through during reset
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h4, 5'd0, 5'd0, 1'b0);
    step(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    idle();

    // LU push with idle WB drains next cycle
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11, 5'd5, 5'd0, 1'b1);
    idle();
    idle();

    // Sustained WB starves buffered r7, hold raised, then drains
    wb_and_lu(5'd1, 5'd7, 32'h77);
    for (int i = 0; i < 6; i++) wb_only(5'd2, 32'h200 + 32'(i));
    idle();
    idle();
    idle();

    // Fill under WB pressure, third push stalls until a drain
    wb_and_lu(5'd1, 5'd10, 32'hA0);
    wb_and_lu(5'd1, 5'd11, 32'hB0);
    wb_and_lu(5'd1, 5'd12, 32'hC0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 5'd0, 5'd0, 1'b1);
    idle();
    idle();
    idle();

    // WAW squash: later WB write to r9 kills the buffered r9
    wb_and_lu(5'd2, 5'd9, 32'hAA);
    step(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b1);
    idle();

    // Hazard lookup and r0 push discard
    wb_and_lu(5'd2, 5'd3, 32'h33);
    step(1'b1, 5'd2, 32'h22, 1'b1, 5'd0, 32'hDEAD, 5'd3, 5'd0, 1'b1);
    step(1'b1, 5'd2, 32'h23, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1);
    idle();
    idle();

    // Reset while holding two entries discards them
    wb_and_lu(5'd1, 5'd13, 32'hD0);
    wb_and_lu(5'd1, 5'd14, 32'hE0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd14, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd14, 1'b1);
    idle();

    // Random traffic, heavier WB pressure in the second half
    for (int c = 0; c < 600; c++) begin
      int unsigned wb_pct;
      wb_pct = (c < 300) ? 50 : 88;
      step($urandom_range(0, 99) < wb_pct, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 63) != 0);
    end
    repeat (DEPTH + 2) idle();

    @(posedge clk);
    #1;
    check_eq("rf_write_count", 64'(dut_wr_cnt), 64'(mdl_wr_cnt));
    check_eq("final_r9", 64'(dut_rf[9]), 64'(mdl_rf[9]));
    for (int r = 1; r < 32; r++) begin
      if (mdl_wr[r]) check_eq("final_rf", 64'(dut_rf[r]), 64'(mdl_rf[r]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
